// File: rtl/sensor_frame_pkg.sv
// Shared types and sizing helpers for the sensor frame packer.
package sensor_frame_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, MASK, DATA, CSUM} frame_state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int mask_bytes(input int num_ch);
    return (num_ch + 7) / 8;
  endfunction

  function automatic int frame_len(input int num_ch, input int sample_w);
    return 3 + mask_bytes(num_ch) + num_ch * (sample_w / 8);
  endfunction

endpackage

// File: rtl/frame_period_timer.sv
// Free-running period counter; tick marks the terminal count while enabled.
module frame_period_timer #(
  parameter int PERIOD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/sensor_frame_packer.sv
// Latches per-channel sensor samples and streams framed snapshots into a UART TX FIFO.
module sensor_frame_packer
  import sensor_frame_pkg::*;
#(
  parameter int          NUM_CH        = 8,
  parameter int          SAMPLE_W      = 16,
  parameter int          PERIOD_CYCLES = 50_000_000,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic                         en,
  input  logic                         mode,
  input  logic                         force_frame,
  output logic [7:0]                   data_to_uart,
  output logic                         data_valid_to_uart,
  input  logic                         uart_fifo_full,
  output logic                         busy,
  output logic [7:0]                   frame_seq,
  output logic [15:0]                  overrun_cnt
);

  localparam int BPS = SAMPLE_W / 8;
  localparam int MB  = mask_bytes(NUM_CH);
  localparam int NB  = NUM_CH * BPS;
  localparam int TW  = NUM_CH * SAMPLE_W;
  localparam int MW  = MB * 8;

  frame_state_t           state, state_next;
  logic [7:0]             idx, idx_next;
  logic                   tick, request, drop_req, start, xfer;
  logic [NUM_CH-1:0]      stale;
  logic [SAMPLE_W-1:0]    sample [NUM_CH];
  logic [TW-1:0]          shadow_data, stream_load;
  logic [MW-1:0]          shadow_mask, mask_load;
  logic [7:0]             seq, csum, byte_out;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  frame_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign busy               = (state != IDLE);
  assign data_valid_to_uart = busy & ~uart_fifo_full;
  assign xfer               = data_valid_to_uart;
  assign data_to_uart       = byte_out;

  // The mode-1 level request is deliberately excluded from overrun counting.
  assign drop_req = force_frame | (en & ~mode & tick);
  assign request  = drop_req | (en & mode & (stale == '0));
  assign start    = (state == IDLE) & request;

  // Pack samples so ch0 MSB sits at the top; DATA bytes then come out by shifting left.
  always_comb begin
    stream_load = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      stream_load[(NUM_CH-1-c)*SAMPLE_W +: SAMPLE_W] = sample[c];
    end
    mask_load = '0;
    mask_load[NUM_CH-1:0] = stale;
  end

  always_comb begin
    case (state)
      SYNC:    byte_out = SYNC_BYTE;
      SEQ:     byte_out = seq;
      MASK:    byte_out = shadow_mask[7:0];
      DATA:    byte_out = shadow_data[TW-1 -: 8];
      CSUM:    byte_out = csum;
      default: byte_out = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (request) state_next = SYNC;
      end
      SYNC: if (xfer) state_next = SEQ;
      SEQ: begin
        idx_next = '0;
        if (xfer) state_next = MASK;
      end
      MASK: if (xfer) begin
        if (idx == 8'(MB - 1)) begin
          state_next = DATA;
          idx_next   = '0;
        end else begin
          idx_next = idx + 8'd1;
        end
      end
      DATA: if (xfer) begin
        if (idx == 8'(NB - 1)) begin
          state_next = CSUM;
          idx_next   = '0;
        end else begin
          idx_next = idx + 8'd1;
        end
      end
      CSUM: if (xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      seq         <= '0;
      csum        <= '0;
      frame_seq   <= '0;
      overrun_cnt <= '0;
      stale       <= '1;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      stale <= start ? ~ch_valid : (stale & ~ch_valid);
      if (busy && drop_req) overrun_cnt <= sat_inc(overrun_cnt);
      if (start) begin
        csum <= '0;
      end else if (xfer && (state == SEQ || state == MASK || state == DATA)) begin
        csum <= csum + byte_out;
      end
      if (xfer && state == CSUM) begin
        frame_seq <= seq;
        seq       <= seq + 8'd1;
      end
    end
  end

  // Live sample registers keep updating; shadows only load at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) sample[k] <= '0;
      shadow_data <= '0;
      shadow_mask <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_valid[k]) sample[k] <= ch_data[k*SAMPLE_W +: SAMPLE_W];
      end
      if (start) begin
        shadow_data <= stream_load;
        shadow_mask <= mask_load;
      end else if (xfer && state == DATA) begin
        shadow_data <= shadow_data << 8;
      end else if (xfer && state == MASK) begin
        shadow_mask <= shadow_mask >> 8;
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Directed bench for sensor_frame_packer with two 16-bit channels and a 100-cycle period.
module tb_sensor_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ch_data;
  logic [1:0]  ch_valid;
  logic        en, mode, force_frame, uart_fifo_full;
  logic [7:0]  data_to_uart;
  logic        data_valid_to_uart, busy;
  logic [7:0]  frame_seq;
  logic [15:0] overrun_cnt;

  int tests = 0;
  int fails = 0;

  sensor_frame_packer #(
    .NUM_CH(2), .SAMPLE_W(16), .PERIOD_CYCLES(100), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ch_data            (ch_data),
    .ch_valid           (ch_valid),
    .en                 (en),
    .mode               (mode),
    .force_frame        (force_frame),
    .data_to_uart       (data_to_uart),
    .data_valid_to_uart (data_valid_to_uart),
    .uart_fifo_full     (uart_fifo_full),
    .busy               (busy),
    .frame_seq          (frame_seq),
    .overrun_cnt        (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame, byte 0 in the top 8 bits; checksum summed over bytes 1..6.
  function automatic logic [63:0] make_frame(input logic [7:0] s, input logic [7:0] m,
                                             input logic [15:0] d0, input logic [15:0] d1);
    logic [7:0] cs;
    cs = s + m + d0[15:8] + d0[7:0] + d1[15:8] + d1[7:0];
    return {8'hA5, s, m, d0, d1, cs};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [63:0] f, input int i);
    return f[63-8*i -: 8];
  endfunction

  task automatic pulse_ch(input logic [1:0] m, input logic [15:0] d0, input logic [15:0] d1);
    @(negedge clk);
    ch_data  = {d1, d0};
    ch_valid = m;
    @(negedge clk);
    ch_valid = 2'b00;
  endtask

  // Receives up to stop_at bytes, optionally kicking a request at cycle 0,
  // stalling the FIFO, or pulsing force_frame during the frame.
  task automatic collect(input logic [63:0] exp, input logic kick_force, input logic [1:0] kick_valid,
                         input int stall_at, input int stall_len, input int force_every,
                         input int stop_at, output int first_cyc, output int pulses);
    int n, cyc, stalled;
    n = 0; cyc = 0; stalled = 0; first_cyc = -1; pulses = 0;
    while (n < stop_at && cyc < 400) begin
      @(negedge clk);
      force_frame = 1'b0; ch_valid = 2'b00; uart_fifo_full = 1'b0;
      if (cyc == 0) begin
        force_frame = kick_force;
        ch_valid    = kick_valid;
      end else if (force_every > 0 && n >= 1 && (cyc % force_every) == 0) begin
        force_frame = 1'b1;
        pulses++;
      end
      if (n == stall_at && stalled < stall_len) begin
        uart_fifo_full = 1'b1;
        stalled++;
      end
      #1;
      if (uart_fifo_full) begin
        check("stall_strobe", 32'(data_valid_to_uart), 32'd0);
        check("stall_hold", 32'(data_to_uart), 32'(exp_byte(exp, n)));
      end else if (data_valid_to_uart) begin
        if (first_cyc < 0) first_cyc = cyc;
        check($sformatf("byte%0d", n), 32'(data_to_uart), 32'(exp_byte(exp, n)));
        n++;
      end
      cyc++;
    end
    check("bytes_seen", 32'(n), 32'(stop_at));
    if (stop_at == 8) begin
      @(posedge clk);
      #1;
      force_frame = 1'b0; ch_valid = 2'b00; uart_fifo_full = 1'b0;
    end
  endtask

  initial begin
    int fc, np, busy_seen;
    logic [63:0] f;

    rst_n = 1'b0; ch_data = '0; ch_valid = '0; en = 1'b1; mode = 1'b0;
    force_frame = 1'b0; uart_fifo_full = 1'b0;
    #1;
    check("rst_valid", 32'(data_valid_to_uart), 32'd0);
    check("rst_data", 32'(data_to_uart), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_seq", 32'(frame_seq), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: both channels fresh, periodic tick
    pulse_ch(2'b11, 16'h1234, 16'hABCD);
    f = make_frame(8'h00, 8'h00, 16'h1234, 16'hABCD);
    check("t1_model_csum", 32'(f[7:0]), 32'hBE);
    collect(f, 1'b0, 2'b00, -1, 0, 0, 8, fc, np);
    check("t1_frame_seq", 32'(frame_seq), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: only ch1 updated, ch0 reported stale
    pulse_ch(2'b10, 16'h0000, 16'h5678);
    f = make_frame(8'h01, 8'h01, 16'h1234, 16'h5678);
    collect(f, 1'b0, 2'b00, -1, 0, 0, 8, fc, np);
    check("t2_frame_seq", 32'(frame_seq), 32'd1);
    @(negedge clk);
    en = 1'b0;

    // 3: FIFO full for 5 cycles in the middle of DATA
    pulse_ch(2'b01, 16'h9ABC, 16'h0000);
    f = make_frame(8'h02, 8'h02, 16'h9ABC, 16'h5678);
    collect(f, 1'b1, 2'b00, 5, 5, 0, 8, fc, np);
    check("t3_latency", 32'(fc), 32'd1);
    check("t3_frame_seq", 32'(frame_seq), 32'd2);

    // 4: force_frame pulses while busy are dropped and counted
    f = make_frame(8'h03, 8'h03, 16'h9ABC, 16'h5678);
    collect(f, 1'b1, 2'b00, -1, 0, 3, 8, fc, np);
    check("t4_overrun", 32'(overrun_cnt), 32'd2);
    check("t4_busy", 32'(busy), 32'd0);
    f = make_frame(8'h04, 8'h03, 16'h9ABC, 16'h5678);
    collect(f, 1'b1, 2'b00, -1, 0, 0, 8, fc, np);
    check("t4_frame_seq", 32'(frame_seq), 32'd4);
    check("t4_overrun_hold", 32'(overrun_cnt), 32'd2);

    // 5: all-fresh mode
    @(negedge clk);
    en = 1'b1; mode = 1'b1;
    ch_data = {16'h2222, 16'h1111};
    f = make_frame(8'h05, 8'h00, 16'h1111, 16'h2222);
    collect(f, 1'b0, 2'b11, -1, 0, 0, 8, fc, np);
    check("t5_latency", 32'(fc), 32'd2);
    pulse_ch(2'b01, 16'h3333, 16'h0000);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (busy) busy_seen++;
    end
    check("t5_no_partial", 32'(busy_seen), 32'd0);
    ch_data = {16'h4444, 16'h3333};
    f = make_frame(8'h06, 8'h00, 16'h3333, 16'h4444);
    collect(f, 1'b0, 2'b10, -1, 0, 0, 8, fc, np);
    check("t5b_latency", 32'(fc), 32'd2);
    check("t5_overrun", 32'(overrun_cnt), 32'd2);

    // 6: asynchronous reset in the middle of DATA
    @(negedge clk);
    en = 1'b0; mode = 1'b0;
    f = make_frame(8'h07, 8'h03, 16'h3333, 16'h4444);
    collect(f, 1'b1, 2'b00, -1, 0, 0, 6, fc, np);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(data_valid_to_uart), 32'd0);
    check("t6_data", 32'(data_to_uart), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_seq", 32'(frame_seq), 32'd0);
    check("t6_ovr", 32'(overrun_cnt), 32'd0);
    force_frame = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t6_held_valid", 32'(data_valid_to_uart), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f = make_frame(8'h00, 8'h03, 16'h0000, 16'h0000);
    collect(f, 1'b1, 2'b00, -1, 0, 0, 8, fc, np);
    check("t6_frame_seq", 32'(frame_seq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
